// File: rtl/mem_port_arbiter_if.sv
// Bundle between two requesters, the arbiter and a shared two-port memory.
// Latency: none; this file only carries signals.
// Backpressure: requesters hold req/addr/data until they see a grant.
interface mem_port_arbiter_if #(
    parameter int addresses = 32,
    parameter int width     = 8
);
    localparam int addressWidth = $clog2(addresses);

    // Write requesters
    logic                    wrReq0;
    logic                    wrReq1;
    logic [addressWidth-1:0] wrAddr0;
    logic [addressWidth-1:0] wrAddr1;
    logic [width-1:0]        wrData0;
    logic [width-1:0]        wrData1;
    logic                    wrGnt0;
    logic                    wrGnt1;

    // Read requesters
    logic                    rdReq0;
    logic                    rdReq1;
    logic [addressWidth-1:0] rdAddr0;
    logic [addressWidth-1:0] rdAddr1;
    logic                    rdGnt0;
    logic                    rdGnt1;
    logic                    rdValid0;
    logic                    rdValid1;
    logic [width-1:0]        rdData;

    // Shared memory ports
    logic [addressWidth-1:0] memWriteAddress;
    logic                    memWriteEnable;
    logic [width-1:0]        memWriteData;
    logic [addressWidth-1:0] memReadAddress;
    logic                    memReadEnable;
    logic [width-1:0]        memReadData;

    // Arbiter side
    modport slave (
        input  wrReq0, wrReq1, wrAddr0, wrAddr1, wrData0, wrData1,
        output wrGnt0, wrGnt1,
        input  rdReq0, rdReq1, rdAddr0, rdAddr1,
        output rdGnt0, rdGnt1, rdValid0, rdValid1, rdData,
        output memWriteAddress, memWriteEnable, memWriteData,
        output memReadAddress, memReadEnable,
        input  memReadData
    );

    // Requesters plus memory side
    modport master (
        output wrReq0, wrReq1, wrAddr0, wrAddr1, wrData0, wrData1,
        input  wrGnt0, wrGnt1,
        output rdReq0, rdReq1, rdAddr0, rdAddr1,
        input  rdGnt0, rdGnt1, rdValid0, rdValid1, rdData,
        input  memWriteAddress, memWriteEnable, memWriteData,
        input  memReadAddress, memReadEnable,
        output memReadData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory write port and one read port between two requesters.
// Latency: grants combinational in the request cycle; read data valid one cycle after read grant.
// Backpressure: a losing requester holds its request and wins within the next cycle.
module mem_port_arbiter #(
    parameter int addresses = 32,
    parameter int width     = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int addressWidth = $clog2(addresses);

    logic                    wrPri;
    logic                    rdPri;
    logic                    wrGnt0;
    logic                    wrGnt1;
    logic                    rdGnt0;
    logic                    rdGnt1;
    logic                    rdValidReg0;
    logic                    rdValidReg1;
    logic [addressWidth-1:0] wrAddrSel;
    logic [width-1:0]        wrDataSel;
    logic [addressWidth-1:0] rdAddrSel;

    // Write arbitration: a lone requester always wins, contention goes to wrPri
    always_comb begin
        wrGnt0 = 1'b0;
        wrGnt1 = 1'b0;
        if (!reset) begin
            if (bus.wrReq0 && bus.wrReq1) begin
                wrGnt0 = ~wrPri;
                wrGnt1 = wrPri;
            end else begin
                wrGnt0 = bus.wrReq0;
                wrGnt1 = bus.wrReq1;
            end
        end
    end

    // Read arbitration: same rule, independent of the write port
    always_comb begin
        rdGnt0 = 1'b0;
        rdGnt1 = 1'b0;
        if (!reset) begin
            if (bus.rdReq0 && bus.rdReq1) begin
                rdGnt0 = ~rdPri;
                rdGnt1 = rdPri;
            end else begin
                rdGnt0 = bus.rdReq0;
                rdGnt1 = bus.rdReq1;
            end
        end
    end

    // Steer the granted requester onto the memory ports; requester 0 when idle
    always_comb begin
        wrAddrSel = wrGnt1 ? bus.wrAddr1 : bus.wrAddr0;
        wrDataSel = wrGnt1 ? bus.wrData1 : bus.wrData0;
        rdAddrSel = rdGnt1 ? bus.rdAddr1 : bus.rdAddr0;
    end

    assign bus.wrGnt0          = wrGnt0;
    assign bus.wrGnt1          = wrGnt1;
    assign bus.rdGnt0          = rdGnt0;
    assign bus.rdGnt1          = rdGnt1;
    assign bus.memWriteEnable  = wrGnt0 | wrGnt1;
    assign bus.memWriteAddress = wrAddrSel;
    assign bus.memWriteData    = wrDataSel;
    assign bus.memReadEnable   = rdGnt0 | rdGnt1;
    assign bus.memReadAddress  = rdAddrSel;

    // Round robin: after a grant, favour the requester that did not get it
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPri <= 1'b0;
            rdPri <= 1'b0;
        end else begin
            if (wrGnt0)      wrPri <= 1'b1;
            else if (wrGnt1) wrPri <= 1'b0;
            if (rdGnt0)      rdPri <= 1'b1;
            else if (rdGnt1) rdPri <= 1'b0;
        end
    end

    // Owner tag for the response the memory returns on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rdValidReg0 <= 1'b0;
            rdValidReg1 <= 1'b0;
        end else begin
            rdValidReg0 <= rdGnt0;
            rdValidReg1 <= rdGnt1;
        end
    end

    // A response still in flight when reset rises is dropped, hence the reset mask
    assign bus.rdValid0 = rdValidReg0 & ~reset;
    assign bus.rdValid1 = rdValidReg1 & ~reset;
    assign bus.rdData   = bus.memReadData;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: addresses, 32, word count of the shared two-port memory.
REQ-002 Parameter: width, 8, data word width in bits.
REQ-003 Localparam: addressWidth, clogb2(addresses), address width; not user settable.
REQ-004 Port: clk  input  1  single clock for all logic and for the shared memory (write and read clocks both tied to clk).
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: wrReq0 / wrReq1  input  1 each  write request from requester 0 / 1.
REQ-007 Port: wrAddr0 / wrAddr1  input  addressWidth each  write address.
REQ-008 Port: wrData0 / wrData1  input  width each  write data.
REQ-009 Port: wrGnt0 / wrGnt1  output  1 each  write grant; combinational, same cycle as accepted request.
REQ-010 Port: rdReq0 / rdReq1  input  1 each  read request.
REQ-011 Port: rdAddr0 / rdAddr1  input  addressWidth each  read address.
REQ-012 Port: rdGnt0 / rdGnt1  output  1 each  read grant; combinational.
REQ-013 Port: rdValid0 / rdValid1  output  1 each  read data valid, registered.
REQ-014 Port: rdData  output  width  read data, shared by both requesters, qualified by rdValid0/1.
REQ-015 Port: memWriteAddress, memWriteEnable (1), memWriteData  output  addressWidth / 1 / width  drive shared memory write port.
REQ-016 Port: memReadAddress, memReadEnable (1)  output  addressWidth / 1  drive shared memory read port.
REQ-017 Port: memReadData  input  width  memory read data, valid one clk after memReadEnable.

Function
REQ-018 Write and read ports SHALL be arbitrated independently; one write grant and one read grant MAY occur in the same cycle.
REQ-019 Per port, at most one grant SHALL be high per cycle; grant only to a requester whose req is high.
REQ-020 Single requester active: grant SHALL be given that cycle (no idle cycles, full throughput).
REQ-021 Both active: grant SHALL go to the requester flagged by that port's priority bit (wrPri / rdPri).
REQ-022 After any grant, priority bit SHALL point to the non-granted requester (round robin); no grant -> bit unchanged.
REQ-023 Requester holds req, addr, data stable until its grant; a requester with req held SHALL be granted within 2 cycles.
REQ-024 memWriteEnable = wrGnt0|wrGnt1; memWriteAddress/memWriteData SHALL be the granted requester's fields (requester 0 fields when idle).
REQ-025 memReadEnable = rdGnt0|rdGnt1; memReadAddress SHALL be the granted requester's address.
REQ-026 Read latency: rdValidN SHALL be high exactly one cycle after rdGntN, for one cycle per grant; rdData = memReadData that cycle.
REQ-027 Back-to-back reads SHALL yield back-to-back rdValid pulses in grant order; owner tag registered per grant.
REQ-028 Same-address read and write granted in the same cycle: returned data SHALL be the pre-write word (no bypass).
REQ-029 Arbiter SHALL not inspect address range; out-of-range addresses are the requester's fault.

Reset
REQ-030 While reset high: all grants, memWriteEnable, memReadEnable SHALL be 0 regardless of requests.
REQ-031 Cycle after reset: rdValid0=rdValid1=0, wrPri=0, rdPri=0 (requester 0 favoured).
REQ-032 Read granted in the cycle before reset asserts SHALL NOT produce rdValid; in-flight response discarded.

Verification
REQ-033 Reset, then wrReq0=wrReq1=1 held 4 cycles, addrs 3/5 -> grants 0,1,0,1; memWriteAddress 3,5,3,5.
REQ-034 Write 0xA5 to addr 7 via req1; next cycle rdReq0 addr 7 -> rdGnt0 same cycle, rdValid0=1 and rdData=0xA5 one cycle later, rdValid1=0.
REQ-035 Addr 2 holds 0x11; same cycle write 0x22 to 2 and read 2 -> rdData=0x11; read again -> 0x22.
REQ-036 rdReq0=rdReq1=1 continuously 6 cycles -> rdValid alternates 0,1,0,1,... with no gap cycles; each requester within 2 cycles.
REQ-037 rdGnt1 in cycle N, reset in cycle N+1 -> rdValid1=0 in N+1 and N+2; rdPri=0 after reset.
REQ-038 Only wrReq1 asserted for 3 cycles -> wrGnt1 every cycle, wrGnt0=0 throughout.
